// File: rtl/wdt_pkg.sv
// Shared constants and helpers for the liveness watchdog.
package wdt_pkg;

    // Width of the cycle counter and of its status readback.
    localparam int unsigned CntWidth = 32;

    // Defaults: 1 s timeout with a warning at 0.75 s, assuming a 125 MHz clock.
    localparam int unsigned DefaultTimeoutCycles = 32'd125_000_000;
    localparam int unsigned DefaultWarningCycles = 32'd93_750_000;

    // Increment with a carry bit, so the add can never silently wrap.
    function automatic logic [CntWidth:0] cnt_inc(input logic [CntWidth-1:0] cnt);
        return {1'b0, cnt} + {{CntWidth{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/watchdog_timer.sv
// Liveness watchdog: counts cycles since the last heartbeat, raises an early
// warning and then a latched timeout fault that downstream logic uses to safe
// the RF output.
module watchdog_timer
    import wdt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
    parameter int unsigned WARNING_CYCLES = DefaultWarningCycles
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                heartbeat,
    input  logic                force_reset,
    input  logic                enable,
    output logic                triggered,
    output logic                warning,
    output logic [CntWidth-1:0] counter
);

    localparam logic [CntWidth:0] TimeoutExt = (CntWidth + 1)'(TIMEOUT_CYCLES);
    localparam logic [CntWidth:0] WarningExt = (CntWidth + 1)'(WARNING_CYCLES);

    logic [CntWidth-1:0] counter_q, counter_d;
    logic                warning_q, warning_d;
    logic                triggered_q, triggered_d;
    logic [CntWidth:0]   cnt_next;

    assign cnt_next = cnt_inc(counter_q);

    // Next-state: clear > disarm > heartbeat > saturate when faulted > count.
    always_comb begin
        counter_d   = counter_q;
        warning_d   = warning_q;
        triggered_d = triggered_q;

        if (force_reset || !enable) begin
            counter_d   = '0;
            warning_d   = 1'b0;
            triggered_d = 1'b0;
        end else if (heartbeat) begin
            // A heartbeat never clears a latched fault. The warning stays up
            // alongside a held fault so that triggered always implies warning.
            counter_d   = '0;
            warning_d   = triggered_q;
        end else if (triggered_q) begin
            warning_d   = 1'b1;
        end else begin
            counter_d   = cnt_next[CntWidth-1:0];
            warning_d   = warning_q || (cnt_next >= WarningExt);
            triggered_d = (cnt_next == TimeoutExt);
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            counter_q   <= '0;
            warning_q   <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            warning_q   <= warning_d;
            triggered_q <= triggered_d;
        end
    end

    assign counter   = counter_q;
    assign warning   = warning_q;
    assign triggered = triggered_q;

`ifdef FORMAL
    // Shadow run length of consecutive armed, heartbeat-free cycles.
    logic [CntWidth:0] run_q;

    // Track how long the watchdog has gone unfed while armed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q <= '0;
        end else if (force_reset || !enable || heartbeat) begin
            run_q <= '0;
        end else if (run_q < TimeoutExt) begin
            run_q <= run_q + 1'b1;
        end
    end

    a_trig_implies_warn: assert property (@(posedge clk) disable iff (!rstn)
        triggered_q |-> warning_q);
    a_cnt_bounded: assert property (@(posedge clk) disable iff (!rstn)
        {1'b0, counter_q} <= TimeoutExt);
    a_trig_needs_run: assert property (@(posedge clk) disable iff (!rstn)
        $rose(triggered_q) |-> run_q == TimeoutExt);
    a_clear_next: assert property (@(posedge clk) disable iff (!rstn)
        (force_reset || !enable) |=> (counter_q == '0 && !warning_q && !triggered_q));
    c_trig_then_clear: cover property (@(posedge clk)
        triggered_q ##[1:$] (!rstn || !enable));
`endif

endmodule

// File: tb/tb_watchdog_timer.sv
// Directed bench for watchdog_timer with a short timeout (16) and warning (12).
module tb_watchdog_timer;

    localparam int unsigned Timeout = 16;
    localparam int unsigned Warn    = 12;

    logic        clk = 1'b0;
    logic        rstn;
    logic        heartbeat;
    logic        force_reset;
    logic        enable;
    logic        triggered;
    logic        warning;
    logic [31:0] counter;

    int vectors     = 0;
    int miscompares = 0;

    watchdog_timer #(
        .TIMEOUT_CYCLES(Timeout),
        .WARNING_CYCLES(Warn)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .heartbeat  (heartbeat),
        .force_reset(force_reset),
        .enable     (enable),
        .triggered  (triggered),
        .warning    (warning),
        .counter    (counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] c, input logic w,
                           input logic t);
        chk({tag, ".counter"}, counter, c);
        chk({tag, ".warning"}, {31'd0, warning}, {31'd0, w});
        chk({tag, ".triggered"}, {31'd0, triggered}, {31'd0, t});
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn        = 1'b0;
        heartbeat   = 1'b0;
        force_reset = 1'b0;
        enable      = 1'b1;

        // Reset state.
        #2;
        chk_all("reset", 32'd0, 1'b0, 1'b0);

        // Release between edges; first count on the next rising edge.
        #6;
        rstn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            chk_all($sformatf("free_run_e%0d", e), (e >= 16) ? 32'd16 : 32'(e),
                    e >= 12, e >= 16);
        end

        // Heartbeat does not clear a latched fault.
        heartbeat = 1'b1;
        step();
        chk_all("hb_while_trig", 32'd0, 1'b1, 1'b1);
        heartbeat = 1'b0;
        step();
        chk_all("trig_hold", 32'd0, 1'b1, 1'b1);

        // Force reset clears everything on the next edge.
        force_reset = 1'b1;
        step();
        chk_all("force_clear", 32'd0, 1'b0, 1'b0);
        force_reset = 1'b0;

        // Heartbeat every 10 cycles keeps the count below the warning level.
        for (int i = 0; i < 100; i++) begin
            heartbeat = ((i % 10) == 9);
            step();
            chk_all($sformatf("hb_periodic_i%0d", i),
                    ((i % 10) == 9) ? 32'd0 : 32'((i % 10) + 1), 1'b0, 1'b0);
        end
        heartbeat = 1'b0;

        // Count to 13, then one disarmed cycle restarts the count.
        repeat (13) step();
        chk_all("count13", 32'd13, 1'b1, 1'b0);
        enable = 1'b0;
        step();
        chk_all("disarm", 32'd0, 1'b0, 1'b0);
        enable = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            chk($sformatf("rearm_trig_e%0d", e), {31'd0, triggered}, {31'd0, e == 16});
        end
        chk("rearm_counter", counter, 32'd16);

        // Heartbeat on the would-be timeout edge wins.
        force_reset = 1'b1;
        step();
        force_reset = 1'b0;
        repeat (15) step();
        chk_all("count15", 32'd15, 1'b1, 1'b0);
        heartbeat = 1'b1;
        step();
        chk_all("hb_on_timeout", 32'd0, 1'b0, 1'b0);
        heartbeat = 1'b0;
        repeat (16) step();
        chk_all("retrigger", 32'd16, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle clears before the next edge.
        #3;
        rstn = 1'b0;
        #1;
        chk_all("async_rst", 32'd0, 1'b0, 1'b0);
        step();
        chk_all("async_rst_held", 32'd0, 1'b0, 1'b0);
        #2;
        rstn = 1'b1;
        step();
        chk_all("fresh_start", 32'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
